// File: rtl/alu_seq_exec.sv
// Sequential RV32 ALU: single-cycle arithmetic/logic/compare ops, iterative shifts.
// Define ALU_SEQ_BARREL_SHIFT_EN to execute shifts in one cycle through a barrel shifter.
module alu_seq_exec #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_ctrl,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_taken,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_XOR  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_BEQ  = 4'b1010;
    localparam logic [3:0] OP_BNE  = 4'b1011;
    localparam logic [3:0] OP_BLT  = 4'b1100;
    localparam logic [3:0] OP_BGE  = 4'b1101;
    localparam logic [3:0] OP_BLTU = 4'b1110;
    localparam logic [3:0] OP_BGEU = 4'b1111;

`ifdef ALU_SEQ_BARREL_SHIFT_EN
    localparam bit BARREL_EN = 1'b1;
`else
    localparam bit BARREL_EN = 1'b0;
`endif

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

    // Single-cycle result; in the iterative build shift codes only reach here with shamt 0.
    function automatic logic [XLEN-1:0] alu_result(input logic [3:0] op,
                                                   input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b);
        logic [XLEN-1:0] r;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_XOR:  r = a ^ b;
            OP_OR:   r = a | b;
            OP_AND:  r = a & b;
`ifdef ALU_SEQ_BARREL_SHIFT_EN
            OP_SLL:  r = a << b[4:0];
            OP_SRL:  r = a >> b[4:0];
            OP_SRA:  r = $unsigned($signed(a) >>> b[4:0]);
`else
            OP_SLL:  r = a;
            OP_SRL:  r = a;
            OP_SRA:  r = a;
`endif
            OP_SLT:  r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: r = {{(XLEN-1){1'b0}}, (a < b)};
            default: r = {XLEN{1'b0}};
        endcase
        return r;
    endfunction

    function automatic logic alu_taken(input logic [3:0] op,
                                       input logic [XLEN-1:0] a,
                                       input logic [XLEN-1:0] b);
        logic t;
        case (op)
            OP_BEQ:  t = (a == b);
            OP_BNE:  t = (a != b);
            OP_BLT:  t = ($signed(a) < $signed(b));
            OP_BGE:  t = ($signed(a) >= $signed(b));
            OP_BLTU: t = (a < b);
            OP_BGEU: t = (a >= b);
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    function automatic logic [XLEN-1:0] shift_step(input logic [3:0] op,
                                                   input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        case (op)
            OP_SLL:  r = {v[XLEN-2:0], 1'b0};
            OP_SRL:  r = {1'b0, v[XLEN-1:1]};
            OP_SRA:  r = {v[XLEN-1], v[XLEN-1:1]};
            default: r = v;
        endcase
        return r;
    endfunction

    state_t          state_r, state_s;
    logic [3:0]      ctrl_r, ctrl_s;
    logic [XLEN-1:0] acc_r, acc_s;
    logic [4:0]      cnt_r, cnt_s;
    logic [XLEN-1:0] result_r, result_s;
    logic            taken_r, taken_s;
    logic            valid_r, valid_s;
    logic [XLEN-1:0] step_s;

    assign in_ready   = (state_r == IDLE) && !flush;
    assign busy       = (state_r != IDLE);
    assign out_valid  = valid_r;
    assign out_result = result_r;
    assign out_taken  = taken_r;

    // Next-state and datapath: flush overrides everything, then accept/shift/handoff.
    always_comb begin
        state_s  = state_r;
        ctrl_s   = ctrl_r;
        acc_s    = acc_r;
        cnt_s    = cnt_r;
        result_s = result_r;
        taken_s  = taken_r;
        valid_s  = valid_r;
        step_s   = shift_step(ctrl_r, acc_r);
        if (flush) begin
            state_s  = IDLE;
            valid_s  = 1'b0;
            result_s = {XLEN{1'b0}};
            taken_s  = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        ctrl_s = in_ctrl;
                        if (!BARREL_EN && is_shift(in_ctrl) && (in_b[4:0] != 5'd0)) begin
                            acc_s   = in_a;
                            cnt_s   = in_b[4:0];
                            state_s = SHIFT;
                        end else begin
                            state_s  = DONE;
                            valid_s  = 1'b1;
                            result_s = alu_result(in_ctrl, in_a, in_b);
                            taken_s  = alu_taken(in_ctrl, in_a, in_b);
                        end
                    end else begin
                        state_s = IDLE;
                    end
                end
                SHIFT: begin
                    // The last step lands directly in DONE so latency is shamt+1.
                    if (cnt_r > 5'd1) begin
                        acc_s = step_s;
                        cnt_s = cnt_r - 5'd1;
                    end else begin
                        acc_s    = step_s;
                        cnt_s    = 5'd0;
                        state_s  = DONE;
                        valid_s  = 1'b1;
                        result_s = step_s;
                        taken_s  = 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_s = IDLE;
                        valid_s = 1'b0;
                    end else begin
                        state_s = DONE;
                    end
                end
                default: begin
                    state_s = IDLE;
                    valid_s = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with asynchronous discard on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            ctrl_r   <= 4'd0;
            acc_r    <= {XLEN{1'b0}};
            cnt_r    <= 5'd0;
            result_r <= {XLEN{1'b0}};
            taken_r  <= 1'b0;
            valid_r  <= 1'b0;
        end else begin
            state_r  <= state_s;
            ctrl_r   <= ctrl_s;
            acc_r    <= acc_s;
            cnt_r    <= cnt_s;
            result_r <= result_s;
            taken_r  <= taken_s;
            valid_r  <= valid_s;
        end
    end

endmodule
